// File: rtl/bus_ic.sv
// Two-master, three-slave bus interconnect: round-robin arbitration, page
// decode with alignment checking, and a watchdog on the slave access phase.
module bus_ic #(
   parameter logic [3:0] S0_PAGE = 4'h0,
   parameter logic [3:0] S1_PAGE = 4'h2,
   parameter logic [3:0] S2_PAGE = 4'h4,
   parameter int         TIMEOUT = 255
) (
   input  logic        bclk,
   input  logic        brst_n,
   input  logic        m0_breq,
   input  logic        m0_bstart,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [1:0]  m0_tsize,
   input  logic        m0_bwrite,
   output logic        m0_bgnt,
   output logic [31:0] m0_rdata,
   output logic        m0_bdone,
   output logic        m0_berror,
   input  logic        m1_breq,
   input  logic        m1_bstart,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [1:0]  m1_tsize,
   input  logic        m1_bwrite,
   output logic        m1_bgnt,
   output logic [31:0] m1_rdata,
   output logic        m1_bdone,
   output logic        m1_berror,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [1:0]  s_tsize,
   output logic        s_bwrite,
   output logic        s_bstart,
   output logic        s0_ss,
   output logic        s1_ss,
   output logic        s2_ss,
   input  logic [31:0] s0_rdata,
   input  logic        s0_bdone,
   input  logic        s0_berror,
   input  logic [31:0] s1_rdata,
   input  logic        s1_bdone,
   input  logic        s1_berror,
   input  logic [31:0] s2_rdata,
   input  logic        s2_bdone,
   input  logic        s2_berror
);

   typedef enum logic [1:0] {IDLE, GRANT, ACCESS, RESP} state_t;

   localparam int             CW  = $clog2(TIMEOUT + 1) + 1;
   localparam logic [CW-1:0]  TMO = CW'(TIMEOUT);

   state_t        state_q;
   logic [1:0]    gnt_q;
   logic [1:0]    done_q;
   logic [1:0]    err_q;
   logic          winner_q;
   logic          last_q;
   logic [31:0]   rdata_q;
   logic [31:0]   s_addr_q;
   logic [31:0]   s_wdata_q;
   logic [1:0]    s_tsize_q;
   logic          s_bwrite_q;
   logic          s_bstart_q;
   logic [2:0]    ss_q;
   logic [CW-1:0] cnt_q;

   logic          win_breq, win_bstart, win_bwrite;
   logic [31:0]   win_addr, win_wdata;
   logic [1:0]    win_tsize;
   logic [1:0]    win_mask;
   logic [3:0]    page;
   logic [2:0]    hit;
   logic          align_err, dec_err;
   logic          pick;
   logic          sel_done, sel_err;
   logic [31:0]   sel_rdata;

   assign win_breq   = winner_q ? m1_breq   : m0_breq;
   assign win_bstart = winner_q ? m1_bstart : m0_bstart;
   assign win_addr   = winner_q ? m1_addr   : m0_addr;
   assign win_wdata  = winner_q ? m1_wdata  : m0_wdata;
   assign win_tsize  = winner_q ? m1_tsize  : m0_tsize;
   assign win_bwrite = winner_q ? m1_bwrite : m0_bwrite;
   assign win_mask   = winner_q ? 2'b10 : 2'b01;

   // Overlapping page parameters resolve to the lowest-numbered slave.
   assign page   = win_addr[31:28];
   assign hit[0] = (page == S0_PAGE);
   assign hit[1] = (page == S1_PAGE) && !hit[0];
   assign hit[2] = (page == S2_PAGE) && !hit[0] && !hit[1];

   assign align_err = (win_tsize == 2'd3)
                    | ((win_tsize == 2'd1) && win_addr[0])
                    | ((win_tsize == 2'd2) && (win_addr[1:0] != 2'b00));
   assign dec_err   = align_err | (hit == 3'b000);

   // With both masters requesting, the one not served last wins.
   assign pick = (m0_breq && m1_breq) ? ~last_q : m1_breq;

   assign sel_done = |(ss_q & {s2_bdone, s1_bdone, s0_bdone});

   always_comb begin
      sel_rdata = '0;
      sel_err   = 1'b0;
      if (ss_q[0]) begin
         sel_rdata = s0_rdata;
         sel_err   = s0_berror;
      end else if (ss_q[1]) begin
         sel_rdata = s1_rdata;
         sel_err   = s1_berror;
      end else if (ss_q[2]) begin
         sel_rdata = s2_rdata;
         sel_err   = s2_berror;
      end
   end

   always_ff @(posedge bclk or negedge brst_n) begin
      if (!brst_n) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         done_q     <= '0;
         err_q      <= '0;
         winner_q   <= 1'b0;
         last_q     <= 1'b1;
         rdata_q    <= '0;
         s_addr_q   <= '0;
         s_wdata_q  <= '0;
         s_tsize_q  <= '0;
         s_bwrite_q <= 1'b0;
         s_bstart_q <= 1'b0;
         ss_q       <= '0;
         cnt_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (m0_breq || m1_breq) begin
                  winner_q <= pick;
                  gnt_q    <= pick ? 2'b10 : 2'b01;
                  state_q  <= GRANT;
               end
            end
            GRANT: begin
               if (!win_breq) begin
                  gnt_q   <= '0;
                  state_q <= IDLE;
               end else if (win_bstart) begin
                  s_addr_q   <= win_addr;
                  s_wdata_q  <= win_wdata;
                  s_tsize_q  <= win_tsize;
                  s_bwrite_q <= win_bwrite;
                  if (dec_err) begin
                     rdata_q <= '0;
                     err_q   <= win_mask;
                     done_q  <= win_mask;
                     state_q <= RESP;
                  end else begin
                     ss_q       <= hit;
                     s_bstart_q <= 1'b1;
                     cnt_q      <= '0;
                     state_q    <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               s_bstart_q <= 1'b0;
               // A response arriving on the timeout cycle still wins.
               if (sel_done) begin
                  rdata_q <= sel_rdata;
                  err_q   <= win_mask & {2{sel_err}};
                  done_q  <= win_mask;
                  ss_q    <= '0;
                  state_q <= RESP;
               end else if (cnt_q == TMO) begin
                  rdata_q <= '0;
                  err_q   <= win_mask;
                  done_q  <= win_mask;
                  ss_q    <= '0;
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               done_q  <= '0;
               err_q   <= '0;
               rdata_q <= '0;
               gnt_q   <= '0;
               last_q  <= winner_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m0_bgnt   = gnt_q[0];
   assign m1_bgnt   = gnt_q[1];
   assign m0_bdone  = done_q[0];
   assign m1_bdone  = done_q[1];
   assign m0_berror = err_q[0];
   assign m1_berror = err_q[1];
   assign m0_rdata  = rdata_q;
   assign m1_rdata  = rdata_q;
   assign s_addr    = s_addr_q;
   assign s_wdata   = s_wdata_q;
   assign s_tsize   = s_tsize_q;
   assign s_bwrite  = s_bwrite_q;
   assign s_bstart  = s_bstart_q;
   assign s0_ss     = ss_q[0];
   assign s1_ss     = ss_q[1];
   assign s2_ss     = ss_q[2];

endmodule

// File: tb/tb_bus_ic.sv
// Directed bench for bus_ic: a vector table of single-master transfers plus
// hand-written arbitration, grant-abandon and mid-access reset sequences.
module tb_bus_ic;

   logic        bclk = 1'b0;
   logic        brst_n = 1'b0;
   logic [1:0]  breq = '0;
   logic [1:0]  bstart = '0;
   logic [31:0] maddr [2];
   logic [31:0] mwdata [2];
   logic [1:0]  mtsize [2];
   logic [1:0]  mbwrite = '0;
   logic [1:0]  bgnt, mbdone, mberror;
   logic [31:0] mrdata [2];
   logic [31:0] s_addr, s_wdata;
   logic [1:0]  s_tsize;
   logic        s_bwrite, s_bstart;
   logic [2:0]  ss;
   logic [31:0] srd [3];
   logic [2:0]  sdone = '0;
   logic [2:0]  serr = '0;

   int checks = 0;
   int failures = 0;

   always #5 bclk = ~bclk;

   bus_ic dut (
      .bclk(bclk), .brst_n(brst_n),
      .m0_breq(breq[0]), .m0_bstart(bstart[0]), .m0_addr(maddr[0]), .m0_wdata(mwdata[0]),
      .m0_tsize(mtsize[0]), .m0_bwrite(mbwrite[0]), .m0_bgnt(bgnt[0]), .m0_rdata(mrdata[0]),
      .m0_bdone(mbdone[0]), .m0_berror(mberror[0]),
      .m1_breq(breq[1]), .m1_bstart(bstart[1]), .m1_addr(maddr[1]), .m1_wdata(mwdata[1]),
      .m1_tsize(mtsize[1]), .m1_bwrite(mbwrite[1]), .m1_bgnt(bgnt[1]), .m1_rdata(mrdata[1]),
      .m1_bdone(mbdone[1]), .m1_berror(mberror[1]),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_tsize(s_tsize), .s_bwrite(s_bwrite),
      .s_bstart(s_bstart), .s0_ss(ss[0]), .s1_ss(ss[1]), .s2_ss(ss[2]),
      .s0_rdata(srd[0]), .s0_bdone(sdone[0]), .s0_berror(serr[0]),
      .s1_rdata(srd[1]), .s1_bdone(sdone[1]), .s1_berror(serr[1]),
      .s2_rdata(srd[2]), .s2_bdone(sdone[2]), .s2_berror(serr[2])
   );

   typedef struct {
      int          m;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  tsize;
      logic        wr;
      logic [2:0]  ess;     // slave select expected during ACCESS
      int          dly;     // ACCESS cycle on which the slave answers, 0 = never
      logic [31:0] srdata;
      logic        serr;
      logic        eerr;
      logic [31:0] erdata;
      int          ecyc;    // expected number of ACCESS cycles
   } vec_t;

   vec_t vt [10];

   task automatic step();
      @(posedge bclk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic do_xfer(input vec_t v, input int idx);
      int          acc;
      int          waited;
      int          sbc;
      logic [2:0]  ss_or;
      logic        got;
      logic [31:0] rd;
      logic        er;
      acc = 0; waited = 0; sbc = 0; ss_or = '0; got = 1'b0; rd = '0; er = 1'b0;
      breq[v.m] = 1'b1;
      step();
      chk($sformatf("v%0d gnt_latency", idx), 32'(bgnt), (v.m == 1) ? 32'd2 : 32'd1);
      for (int i = 0; i < 5 && bgnt[v.m] !== 1'b1; i++) step();
      maddr[v.m] = v.addr; mwdata[v.m] = v.wdata; mtsize[v.m] = v.tsize;
      mbwrite[v.m] = v.wr; bstart[v.m] = 1'b1;
      step();
      bstart[v.m] = 1'b0;
      waited = 1;
      for (int i = 0; i < 400; i++) begin
         if (mbdone[v.m] === 1'b1) begin
            got = 1'b1; rd = mrdata[v.m]; er = mberror[v.m];
            break;
         end
         sbc += 32'(s_bstart);
         if (ss != 3'b000) begin
            ss_or |= ss;
            acc++;
            for (int j = 0; j < 3; j++) begin
               if (!ss[j]) begin
                  sdone[j] = 1'b1; serr[j] = 1'b1; srd[j] = 32'hBAD0_0000;
               end else if (acc == v.dly) begin
                  sdone[j] = 1'b1; serr[j] = v.serr; srd[j] = v.srdata;
               end
            end
         end
         step();
         sdone = '0; serr = '0;
         for (int j = 0; j < 3; j++) srd[j] = '0;
         waited++;
      end
      chk($sformatf("v%0d bdone", idx), 32'(got), 32'd1);
      chk($sformatf("v%0d other_bdone", idx), 32'(mbdone[1-v.m]), 32'd0);
      chk($sformatf("v%0d bgnt_in_resp", idx), 32'(bgnt[v.m]), 32'd1);
      chk($sformatf("v%0d berror", idx), 32'(er), 32'(v.eerr));
      chk($sformatf("v%0d rdata", idx), rd, v.erdata);
      chk($sformatf("v%0d ss", idx), 32'(ss_or), 32'(v.ess));
      chk($sformatf("v%0d access_cycles", idx), 32'(acc), 32'(v.ecyc));
      chk($sformatf("v%0d bdone_latency", idx), 32'(waited), 32'(v.ecyc + 1));
      chk($sformatf("v%0d s_bstart_cycles", idx), 32'(sbc), (v.ess != 3'b000) ? 32'd1 : 32'd0);
      if (v.ess != 3'b000) begin
         chk($sformatf("v%0d s_addr", idx), s_addr, v.addr);
         chk($sformatf("v%0d s_wdata", idx), s_wdata, v.wdata);
         chk($sformatf("v%0d s_ctl", idx), 32'({s_tsize, s_bwrite}), 32'({v.tsize, v.wr}));
      end
      breq[v.m] = 1'b0;
      step();
      chk($sformatf("v%0d gnt_release", idx), 32'(bgnt), 32'd0);
      $display("xfer v%0d m%0d addr=%h ss=%b cycles=%0d berror=%0d rdata=%h",
               idx, v.m, v.addr, ss_or, acc, er, rd);
   endtask

   // Drives an unmapped-page start for master m and walks through RESP into IDLE.
   task automatic quick_err(input int m, input string nm);
      maddr[m] = 32'h8000_0000; mtsize[m] = 2'd2; mbwrite[m] = 1'b0; bstart[m] = 1'b1;
      step();
      bstart[m] = 1'b0;
      chk({nm, "_bdone"}, 32'({mbdone, mberror}), (m == 1) ? 32'b1010 : 32'b0101);
      chk({nm, "_no_ss"}, 32'({ss, s_bstart}), 32'd0);
      breq[m] = 1'b0;
      step();
      chk({nm, "_idle_gap"}, 32'(bgnt), 32'd0);
      $display("xfer %s m%0d decode-error", nm, m);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         maddr[i] = '0; mwdata[i] = '0; mtsize[i] = '0;
      end
      for (int j = 0; j < 3; j++) srd[j] = '0;

      vt[0] = '{0, 32'h2000_0010, 32'h0,         2'd2, 1'b0, 3'b010, 3,   32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 3};
      vt[1] = '{1, 32'h8000_0000, 32'h1111_2222, 2'd2, 1'b1, 3'b000, 0,   32'h0,         1'b0, 1'b1, 32'h0,         0};
      vt[2] = '{0, 32'h0000_0002, 32'h0,         2'd2, 1'b0, 3'b000, 0,   32'h0,         1'b0, 1'b1, 32'h0,         0};
      vt[3] = '{0, 32'h4000_0001, 32'h0,         2'd1, 1'b0, 3'b000, 0,   32'h0,         1'b0, 1'b1, 32'h0,         0};
      vt[4] = '{1, 32'h0000_0003, 32'h0,         2'd0, 1'b0, 3'b001, 1,   32'h0000_0012, 1'b0, 1'b0, 32'h0000_0012, 1};
      vt[5] = '{0, 32'h4000_0002, 32'h5555_AAAA, 2'd1, 1'b1, 3'b100, 2,   32'hA5A5_0000, 1'b1, 1'b1, 32'hA5A5_0000, 2};
      vt[6] = '{1, 32'h2000_0000, 32'h0,         2'd3, 1'b0, 3'b000, 0,   32'h0,         1'b0, 1'b1, 32'h0,         0};
      vt[7] = '{1, 32'h2000_0007, 32'h0000_00CC, 2'd0, 1'b1, 3'b010, 1,   32'h0,         1'b0, 1'b0, 32'h0,         1};
      vt[8] = '{1, 32'h4000_0100, 32'h0,         2'd2, 1'b0, 3'b100, 0,   32'h0,         1'b0, 1'b1, 32'h0,         256};
      vt[9] = '{0, 32'h4000_0200, 32'h0,         2'd2, 1'b0, 3'b100, 256, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0BAD_F00D, 256};

      #3;
      chk("reset_outputs", 32'({bgnt, mbdone, mberror, ss, s_bstart, s_bwrite, s_tsize}), 32'd0);
      chk("reset_s_addr", s_addr | s_wdata | mrdata[0] | mrdata[1], 32'd0);
      step();
      brst_n = 1'b1;
      step();

      // Simultaneous requests from reset, twice: m0 then m1 each time.
      breq = 2'b11;
      step();
      chk("arb1_first_m0", 32'(bgnt), 32'd1);
      quick_err(0, "arb1_m0");
      step();
      chk("arb1_then_m1", 32'(bgnt), 32'd2);
      quick_err(1, "arb1_m1");
      breq = 2'b11;
      step();
      chk("arb2_first_m0", 32'(bgnt), 32'd1);
      quick_err(0, "arb2_m0");
      step();
      chk("arb2_then_m1", 32'(bgnt), 32'd2);
      quick_err(1, "arb2_m1");

      // m0 abandons its grant; the last-served pointer must still say m1.
      breq = 2'b01;
      step();
      chk("abandon_gnt", 32'(bgnt), 32'd1);
      breq = 2'b00;
      step();
      chk("abandon_cleared", 32'(bgnt), 32'd0);
      breq = 2'b11;
      step();
      chk("abandon_ptr_m0", 32'(bgnt), 32'd1);
      quick_err(0, "abandon_m0");
      step();
      chk("abandon_then_m1", 32'(bgnt), 32'd2);
      quick_err(1, "abandon_m1");

      for (int i = 0; i < 10; i++) do_xfer(vt[i], i);

      // Reset in the middle of an access to a silent slave.
      breq = 2'b01;
      step();
      maddr[0] = 32'h2000_0000; mtsize[0] = 2'd2; mbwrite[0] = 1'b0; bstart[0] = 1'b1;
      step();
      bstart[0] = 1'b0;
      chk("rst_pre_ss", 32'(ss), 32'b010);
      step();
      brst_n = 1'b0;
      #1;
      chk("rst_async_ctl", 32'({bgnt, mbdone, mberror, ss, s_bstart}), 32'd0);
      chk("rst_async_data", s_addr | mrdata[0], 32'd0);
      step();
      chk("rst_no_bdone", 32'(mbdone), 32'd0);
      brst_n = 1'b1;
      breq = 2'b11;
      step();
      chk("rst_then_m0", 32'(bgnt), 32'd1);
      quick_err(0, "rst_m0");
      step();
      chk("rst_then_m1", 32'(bgnt), 32'd2);
      quick_err(1, "rst_m1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
